lc3_control_fsm: RTL

LC3_CONTROL_FSM -- requirements
Module: lc3_control_fsm

---
 rtl/lc3_ctrl_pkg.sv | 69 ++++++
 rtl/lc3_bypass_unit.sv | 34 +++
 rtl/lc3_control_fsm.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/lc3_ctrl_pkg.sv
// Shared definitions for the LC-3 pipeline controller: opcodes, FSM states,
// memory-access encodings and opcode class decoders.
package lc3_ctrl_pkg;

   localparam int unsigned INSTR_W = 16;
   localparam int unsigned OP_W    = 4;
   localparam int unsigned ST_W    = 2;
   localparam int unsigned MS_W    = 2;
   localparam int unsigned FILL_W  = 3;
   localparam int unsigned CC_W    = 3;

   localparam logic [OP_W-1:0] OP_BR  = 4'b0000;
   localparam logic [OP_W-1:0] OP_ADD = 4'b0001;
   localparam logic [OP_W-1:0] OP_LD  = 4'b0010;
   localparam logic [OP_W-1:0] OP_ST  = 4'b0011;
   localparam logic [OP_W-1:0] OP_AND = 4'b0101;
   localparam logic [OP_W-1:0] OP_LDR = 4'b0110;
   localparam logic [OP_W-1:0] OP_STR = 4'b0111;
   localparam logic [OP_W-1:0] OP_NOT = 4'b1001;
   localparam logic [OP_W-1:0] OP_LDI = 4'b1010;
   localparam logic [OP_W-1:0] OP_STI = 4'b1011;
   localparam logic [OP_W-1:0] OP_JMP = 4'b1100;
   localparam logic [OP_W-1:0] OP_LEA = 4'b1110;

   localparam logic [ST_W-1:0] ST_FILL  = 2'd0;
   localparam logic [ST_W-1:0] ST_RUN   = 2'd1;
   localparam logic [ST_W-1:0] ST_MEM   = 2'd2;
   localparam logic [ST_W-1:0] ST_FLUSH = 2'd3;

   localparam logic [MS_W-1:0] MS_READ  = 2'd0;
   localparam logic [MS_W-1:0] MS_IND   = 2'd1;
   localparam logic [MS_W-1:0] MS_WRITE = 2'd2;
   localparam logic [MS_W-1:0] MS_IDLE  = 2'd3;

   // LEA writes a destination register, so it forwards like an ALU op.
   function automatic logic is_alu(input logic [OP_W-1:0] op);
      return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT) || (op == OP_LEA);
   endfunction

   function automatic logic is_addand(input logic [OP_W-1:0] op);
      return (op == OP_ADD) || (op == OP_AND);
   endfunction

   function automatic logic is_load(input logic [OP_W-1:0] op);
      return (op == OP_LD) || (op == OP_LDR) || (op == OP_LDI);
   endfunction

   function automatic logic is_store(input logic [OP_W-1:0] op);
      return (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
   endfunction

   function automatic logic is_ctrl(input logic [OP_W-1:0] op);
      return (op == OP_BR) || (op == OP_JMP);
   endfunction

   function automatic logic [MS_W-1:0] mem_first(input logic [OP_W-1:0] op);
      if ((op == OP_LDI) || (op == OP_STI)) return MS_IND;
      if (is_load(op)) return MS_READ;
      return MS_WRITE;
   endfunction

   // Indirect accesses fetch the pointer first, then do the real access.
   function automatic logic [MS_W-1:0] mem_next(input logic [OP_W-1:0] op,
                                                input logic [MS_W-1:0] cur);
      if (cur == MS_IND) return (op == OP_LDI) ? MS_READ : MS_WRITE;
      return MS_IDLE;
   endfunction

endpackage

// File: rtl/lc3_bypass_unit.sv
// Operand forwarding selects: compares the execute-stage destination with
// the decode-stage sources; gated off while the pipeline is not running.
module lc3_bypass_unit
   import lc3_ctrl_pkg::*;
(
   input  logic               active,
   input  logic [INSTR_W-1:0] ir,
   input  logic [INSTR_W-1:0] ir_exec,
   output logic               bypass_alu_1,
   output logic               bypass_alu_2,
   output logic               bypass_mem_1,
   output logic               bypass_mem_2
);

   logic [OP_W-1:0] dec_op;
   logic [OP_W-1:0] exe_op;
   logic            src1_hit;
   logic            src2_hit;
   logic            unused_fields;

   assign dec_op        = ir[15:12];
   assign exe_op        = ir_exec[15:12];
   assign unused_fields = ^{ir[11:9], ir[4:3], ir_exec[8:0]};

   always_comb begin
      src1_hit     = (is_alu(dec_op) || is_store(dec_op)) && (ir_exec[11:9] == ir[8:6]);
      src2_hit     = is_addand(dec_op) && !ir[5] && (ir_exec[11:9] == ir[2:0]);
      bypass_alu_1 = active && is_alu(exe_op)  && src1_hit;
      bypass_alu_2 = active && is_alu(exe_op)  && src2_hit;
      bypass_mem_1 = active && is_load(exe_op) && src1_hit;
      bypass_mem_2 = active && is_load(exe_op) && src2_hit;
   end

endmodule

// File: rtl/lc3_control_fsm.sv
// LC-3 pipeline controller: stage enables, branch redirect/flush and the
// data-memory access sequencer. All outputs except bypass selects are registered.
module lc3_control_fsm
   import lc3_ctrl_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   input  logic               completed_instr,
   input  logic               completed_data,
   input  logic [INSTR_W-1:0] IR,
   input  logic [INSTR_W-1:0] IR_EXEC,
   input  logic [CC_W-1:0]    NZP,
   input  logic [CC_W-1:0]    PSR,
   input  logic [INSTR_W-1:0] Imem_dout,
   output logic               enable_updatePC,
   output logic               enable_fetch,
   output logic               enable_decode,
   output logic               enable_execute,
   output logic               enable_writeback,
   output logic               br_taken,
   output logic               bypass_alu_1,
   output logic               bypass_alu_2,
   output logic               bypass_mem_1,
   output logic               bypass_mem_2,
   output logic [MS_W-1:0]    mem_state
);

   logic [ST_W-1:0]   state, state_d;
   logic [FILL_W-1:0] fill, fill_d;
   logic              flush_cnt, flush_d;
   logic [OP_W-1:0]   mem_op, mem_op_d;
   logic              upc_d, fetch_d, dec_d, exe_d, wb_d, br_d;
   logic [MS_W-1:0]   ms_d;

   logic [OP_W-1:0]   exe_op;
   logic              taken_c;
   logic              run_upc_c;
   logic [MS_W-1:0]   ms_next_c;
   logic              unused_inputs;

   assign exe_op        = IR_EXEC[15:12];
   assign taken_c       = ((exe_op == OP_BR) && |(IR_EXEC[11:9] & NZP)) || (exe_op == OP_JMP);
   assign ms_next_c     = mem_next(mem_op, mem_state);
   assign unused_inputs = ^{PSR, Imem_dout[11:0]};

   // Hold the PC while a control instruction is in fetch or decode.
   assign run_upc_c = completed_instr && !is_ctrl(IR[15:12]) && !is_ctrl(Imem_dout[15:12]);

   always_comb begin
      state_d  = state;
      fill_d   = fill;
      flush_d  = flush_cnt;
      mem_op_d = mem_op;
      upc_d    = 1'b0;
      fetch_d  = 1'b0;
      dec_d    = 1'b0;
      exe_d    = 1'b0;
      wb_d     = 1'b0;
      br_d     = 1'b0;
      ms_d     = MS_IDLE;
      case (state)
         ST_FILL: begin
            fill_d  = {fill[FILL_W-2:0], 1'b1};
            upc_d   = 1'b1;
            fetch_d = 1'b1;
            dec_d   = fill[0];
            exe_d   = fill[1];
            wb_d    = fill[2];
            if (fill[2]) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (taken_c) begin
               state_d = ST_FLUSH;
               flush_d = 1'b0;
               br_d    = 1'b1;
               upc_d   = 1'b1;
               fetch_d = 1'b1;
            end else if (is_load(exe_op) || is_store(exe_op)) begin
               state_d  = ST_MEM;
               mem_op_d = exe_op;
               ms_d     = mem_first(exe_op);
            end else begin
               upc_d   = run_upc_c;
               fetch_d = completed_instr;
               dec_d   = completed_instr;
               exe_d   = 1'b1;
               wb_d    = 1'b1;
            end
         end
         ST_MEM: begin
            // Idle cycle after the last access carries the load writeback.
            if (mem_state == MS_IDLE) begin
               state_d = ST_RUN;
               upc_d   = run_upc_c;
               fetch_d = completed_instr;
               dec_d   = completed_instr;
               exe_d   = 1'b1;
               wb_d    = 1'b1;
            end else if (completed_data) begin
               ms_d = ms_next_c;
               wb_d = (ms_next_c == MS_IDLE) && is_load(mem_op);
            end else begin
               ms_d = mem_state;
            end
         end
         ST_FLUSH: begin
            if (!flush_cnt) begin
               flush_d = 1'b1;
               upc_d   = 1'b1;
               fetch_d = 1'b1;
            end else begin
               state_d = ST_RUN;
               upc_d   = run_upc_c;
               fetch_d = completed_instr;
               dec_d   = completed_instr;
               exe_d   = 1'b1;
               wb_d    = 1'b1;
            end
         end
         default: state_d = ST_FILL;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state            <= ST_FILL;
         fill             <= '0;
         flush_cnt        <= 1'b0;
         mem_op           <= '0;
         enable_updatePC  <= 1'b0;
         enable_fetch     <= 1'b0;
         enable_decode    <= 1'b0;
         enable_execute   <= 1'b0;
         enable_writeback <= 1'b0;
         br_taken         <= 1'b0;
         mem_state        <= MS_IDLE;
      end else begin
         state            <= state_d;
         fill             <= fill_d;
         flush_cnt        <= flush_d;
         mem_op           <= mem_op_d;
         enable_updatePC  <= upc_d;
         enable_fetch     <= fetch_d;
         enable_decode    <= dec_d;
         enable_execute   <= exe_d;
         enable_writeback <= wb_d;
         br_taken         <= br_d;
         mem_state        <= ms_d;
      end
   end

   lc3_bypass_unit u_bypass (
      .active       ((state == ST_RUN) || (state == ST_FLUSH)),
      .ir           (IR),
      .ir_exec      (IR_EXEC),
      .bypass_alu_1 (bypass_alu_1),
      .bypass_alu_2 (bypass_alu_2),
      .bypass_mem_1 (bypass_mem_1),
      .bypass_mem_2 (bypass_mem_2)
   );

endmodule
